// File: rtl/ascon_pkg.sv
// rtl/ascon_pkg.sv - shared state encoding, default sizes and pad byte for the Ascon byte loader
package ascon_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_KEY   = 3'd1,
        S_NONCE = 3'd2,
        S_DATA  = 3'd3,
        S_HAND  = 3'd4
    } state_t;

    localparam int DEF_KEY_BYTES = 16;
    localparam int DEF_BLK_BYTES = 8;
    localparam logic [7:0] ASCON_PAD_BYTE = 8'h80;

endpackage

// File: rtl/ascon_byte_shifter.sv
// rtl/ascon_byte_shifter.sv - byte-wide left shift register with synchronous clear
module ascon_byte_shifter #(
    parameter int BYTES = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               shift,
    input  logic [7:0]         in_byte,
    output logic [8*BYTES-1:0] data
);

    // Oldest byte drifts toward the MSB, so a full register is big-endian.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
        end else if (clr) begin
            data <= '0;
        end else if (shift) begin
            data <= {data[8*BYTES-9:0], in_byte};
        end
    end

endmodule

// File: rtl/ascon_byte_loader.sv
// rtl/ascon_byte_loader.sv - loads key, nonce and rate blocks from a byte bus; ASCON_LOADER_PAD_EN enables 10* padding
module ascon_byte_loader
    import ascon_pkg::*;
#(
    parameter int KEY_BYTES = DEF_KEY_BYTES,
    parameter int BLK_BYTES = DEF_BLK_BYTES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [7:0]             in_byte,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic [8*KEY_BYTES-1:0] key_out,
    output logic [8*KEY_BYTES-1:0] nonce_out,
    output logic                   kn_valid,
    output logic [8*BLK_BYTES-1:0] blk_out,
    output logic [3:0]             blk_bytes,
    output logic                   blk_valid,
    output logic                   blk_last,
    input  logic                   blk_ready
);

    localparam int BW = 8 * BLK_BYTES;

    state_t        state, state_next;
    logic [7:0]    cnt;
    logic          pad_pending;
    logic [BW-1:0] blk_sr;
    logic          xfer, field_done, blk_full;
    logic          key_shift, nonce_shift, blk_shift, blk_clr, hand_done;

    assign in_ready   = (state == S_KEY) || (state == S_NONCE) || (state == S_DATA);
    assign blk_valid  = (state == S_HAND);
    assign xfer       = in_valid && in_ready;
    assign field_done = (cnt == 8'(KEY_BYTES - 1));
    assign blk_full   = (blk_bytes == 4'(BLK_BYTES - 1));

    always_comb begin
        state_next  = state;
        key_shift   = 1'b0;
        nonce_shift = 1'b0;
        blk_shift   = 1'b0;
        blk_clr     = 1'b0;
        hand_done   = 1'b0;
        if (start) begin
            state_next = S_KEY;
        end else begin
            case (state)
                S_IDLE: ;
                S_KEY: if (xfer) begin
                    key_shift = 1'b1;
                    if (field_done) state_next = S_NONCE;
                end
                S_NONCE: if (xfer) begin
                    nonce_shift = 1'b1;
                    if (field_done) state_next = S_DATA;
                end
                S_DATA: if (xfer) begin
                    blk_shift = 1'b1;
                    if (blk_full || in_last) state_next = S_HAND;
                end
                S_HAND: if (blk_ready) begin
                    hand_done = 1'b1;
                    blk_clr   = 1'b1;
                    // A pending pad block is presented straight away without leaving HAND.
                    if (pad_pending)   state_next = S_HAND;
                    else if (blk_last) state_next = S_IDLE;
                    else               state_next = S_DATA;
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            kn_valid    <= 1'b0;
            blk_bytes   <= '0;
            blk_last    <= 1'b0;
            pad_pending <= 1'b0;
        end else begin
            state <= state_next;
            if (start) begin
                cnt         <= '0;
                kn_valid    <= 1'b0;
                blk_bytes   <= '0;
                blk_last    <= 1'b0;
                pad_pending <= 1'b0;
            end else begin
                if (key_shift || nonce_shift) cnt <= field_done ? 8'd0 : cnt + 8'd1;
                if (nonce_shift && field_done) kn_valid <= 1'b1;
                if (blk_shift) begin
                    blk_bytes <= blk_bytes + 4'd1;
                    if (in_last) begin
`ifdef ASCON_LOADER_PAD_EN
                        if (blk_full) pad_pending <= 1'b1;
                        else          blk_last    <= 1'b1;
`else
                        blk_last <= 1'b1;
`endif
                    end
                end
                if (hand_done) begin
                    blk_bytes   <= '0;
                    blk_last    <= pad_pending;
                    pad_pending <= 1'b0;
                end
            end
        end
    end

    ascon_byte_shifter #(.BYTES(KEY_BYTES)) u_key (
        .clk(clk), .rst(rst), .clr(start), .shift(key_shift), .in_byte(in_byte), .data(key_out)
    );

    ascon_byte_shifter #(.BYTES(KEY_BYTES)) u_nonce (
        .clk(clk), .rst(rst), .clr(start), .shift(nonce_shift), .in_byte(in_byte), .data(nonce_out)
    );

    ascon_byte_shifter #(.BYTES(BLK_BYTES)) u_blk (
        .clk(clk), .rst(rst), .clr(start || blk_clr), .shift(blk_shift), .in_byte(in_byte), .data(blk_sr)
    );

    // Short blocks sit right-aligned in the shifter; left-align them so unused bytes read as zero.
    always_comb begin
        blk_out = blk_sr << (BW - 8 * int'(blk_bytes));
`ifdef ASCON_LOADER_PAD_EN
        if (blk_last) blk_out = blk_out | ({ASCON_PAD_BYTE, {(BW-8){1'b0}}} >> (8 * int'(blk_bytes)));
`endif
    end

endmodule

// File: tb/tb_ascon_byte_loader.sv
// tb/tb_ascon_byte_loader.sv - randomized self-checking bench for ascon_byte_loader against a block-splitting model
module tb_ascon_byte_loader;

    localparam int KB = 16;
    localparam int BB = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [7:0]   in_byte = 8'h00;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic         blk_ready = 1'b0;
    logic         in_ready;
    logic [127:0] key_out, nonce_out;
    logic         kn_valid;
    logic [63:0]  blk_out;
    logic [3:0]   blk_bytes;
    logic         blk_valid, blk_last;

    ascon_byte_loader #(.KEY_BYTES(KB), .BLK_BYTES(BB)) dut (
        .clk(clk), .rst(rst), .start(start), .in_byte(in_byte), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .key_out(key_out), .nonce_out(nonce_out),
        .kn_valid(kn_valid), .blk_out(blk_out), .blk_bytes(blk_bytes), .blk_valid(blk_valid),
        .blk_last(blk_last), .blk_ready(blk_ready)
    );

    always #5 clk = ~clk;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [63:0] data;
        logic [3:0]  nb;
        logic        last;
    } blk_t;

    blk_t exp_q[$];
    blk_t obs_q[$];
    int   total = 0;
    int   bad = 0;

    // Reference: split the message into rate-sized chunks, left-aligned, zero-filled, then pad.
    task automatic model_blocks(input bq_t msg);
        int n, off, k;
        blk_t b;
        exp_q.delete();
        n = msg.size();
        off = 0;
        while (off < n) begin
            k = (n - off > BB) ? BB : n - off;
            b.data = '0;
            for (int j = 0; j < k; j++) b.data[63-8*j -: 8] = msg[off+j];
            b.nb = 4'(k);
            b.last = (off + k == n);
`ifdef ASCON_LOADER_PAD_EN
            if (b.last && k < BB) begin
                b.data[63-8*k -: 8] = 8'h80;
            end else if (b.last) begin
                b.last = 1'b0;
                exp_q.push_back(b);
                b.data = 64'h8000_0000_0000_0000;
                b.nb = 4'd0;
                b.last = 1'b1;
            end
`endif
            exp_q.push_back(b);
            off += k;
        end
    endtask

    task automatic load_kn(input logic [127:0] k, input logic [127:0] n, input bit drop);
        int i, cyc;
        @(negedge clk);
        start = 1'b1;
        in_valid = drop;
        in_byte = 8'hEE;
        in_last = 1'b0;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b0;
        total++; if (kn_valid !== 1'b0) begin bad++; $display("FAIL kn_after_start got=%b want=0", kn_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ready_in_key got=%b want=1", in_ready); end
        i = 0;
        cyc = 0;
        while (i < 2*KB && cyc < 1000) begin
            in_byte = (i < KB) ? k[127-8*i -: 8] : n[127-8*(i-KB) -: 8];
            in_last = 1'($urandom_range(0, 1));
            in_valid = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_valid) i++;
            cyc++;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        total++; if (kn_valid !== 1'b1) begin bad++; $display("FAIL kn_valid got=%b want=1", kn_valid); end
        total++; if (key_out !== k) begin bad++; $display("FAIL key_out got=%h want=%h", key_out, k); end
        total++; if (nonce_out !== n) begin bad++; $display("FAIL nonce_out got=%h want=%h", nonce_out, n); end
        total++; if (blk_valid !== 1'b0) begin bad++; $display("FAIL blk_valid_after_kn got=%b want=0", blk_valid); end
    endtask

    task automatic run_msg(input bq_t msg, input int stall);
        int n, idx, bi, cyc, stall_left;
        bit seen, stalled;
        blk_t cur, hold;
        model_blocks(msg);
        obs_q.delete();
        n = msg.size();
        idx = 0; bi = 0; cyc = 0; stall_left = 0;
        seen = 1'b0; stalled = 1'b0;
        while (bi < exp_q.size() && cyc < 3000) begin
            in_valid = 1'b0; in_last = 1'b0; blk_ready = 1'b0;
            if (blk_valid) begin
                cur.data = blk_out; cur.nb = blk_bytes; cur.last = blk_last;
                total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL ready_in_hand got=%b want=0", in_ready); end
                if (!seen) begin
                    seen = 1'b1;
                    hold = cur;
                    obs_q.push_back(cur);
                    total++; if (cur.data !== exp_q[bi].data) begin bad++; $display("FAIL blk_out[%0d] got=%h want=%h", bi, cur.data, exp_q[bi].data); end
                    total++; if (cur.nb !== exp_q[bi].nb) begin bad++; $display("FAIL blk_bytes[%0d] got=%0d want=%0d", bi, cur.nb, exp_q[bi].nb); end
                    total++; if (cur.last !== exp_q[bi].last) begin bad++; $display("FAIL blk_last[%0d] got=%b want=%b", bi, cur.last, exp_q[bi].last); end
                    if (bi == 0 && stall > 0 && !stalled) begin stalled = 1'b1; stall_left = stall; end
                end else begin
                    total++;
                    if ({cur.data, cur.nb, cur.last} !== {hold.data, hold.nb, hold.last}) begin
                        bad++; $display("FAIL blk_stable[%0d] got=%h/%0d/%b want=%h/%0d/%b", bi,
                            cur.data, cur.nb, cur.last, hold.data, hold.nb, hold.last);
                    end
                end
                if (idx < n) begin in_byte = msg[idx]; in_last = (idx == n-1); in_valid = 1'b1; end
                if (stall_left > 0) stall_left--;
                else blk_ready = ($urandom_range(0, 2) != 0);
                if (blk_ready) begin bi++; seen = 1'b0; end
            end else if (in_ready && idx < n) begin
                in_byte = msg[idx];
                in_last = (idx == n-1);
                in_valid = ($urandom_range(0, 3) != 0);
                if (in_valid) idx++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0; in_last = 1'b0; blk_ready = 1'b0;
        total++; if (bi != exp_q.size()) begin bad++; $display("FAIL msg_timeout got=%0d want=%0d blocks", bi, exp_q.size()); end
        total++; if (idx != n) begin bad++; $display("FAIL bytes_consumed got=%0d want=%0d", idx, n); end
        total++; if ({blk_valid, in_ready} !== 2'b00) begin bad++; $display("FAIL idle_after_msg got=%b want=00", {blk_valid, in_ready}); end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
        total++; if (kn_valid !== 1'b0) begin bad++; $display("FAIL rst_kn_valid got=%b want=0", kn_valid); end
        total++; if (blk_valid !== 1'b0) begin bad++; $display("FAIL rst_blk_valid got=%b want=0", blk_valid); end
        total++; if (blk_last !== 1'b0) begin bad++; $display("FAIL rst_blk_last got=%b want=0", blk_last); end
        total++; if (key_out !== '0) begin bad++; $display("FAIL rst_key_out got=%h want=0", key_out); end
        total++; if (nonce_out !== '0) begin bad++; $display("FAIL rst_nonce_out got=%h want=0", nonce_out); end
        total++; if (blk_out !== '0) begin bad++; $display("FAIL rst_blk_out got=%h want=0", blk_out); end
        total++; if (blk_bytes !== 4'd0) begin bad++; $display("FAIL rst_blk_bytes got=%0d want=0", blk_bytes); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL idle_in_ready got=%b want=0", in_ready); end
    endtask

    task automatic test_vectors();
        bq_t m;
        logic [63:0] want;
        load_kn(128'h000102030405060708090A0B0C0D0E0F, 128'h101112131415161718191A1B1C1D1E1F, 1'b0);
        m = '{8'hAA, 8'hBB, 8'hCC};
        run_msg(m, 0);
`ifdef ASCON_LOADER_PAD_EN
        want = 64'hAABBCC8000000000;
`else
        want = 64'hAABBCC0000000000;
`endif
        total++;
        if (obs_q.size() != 1 || obs_q[0].data !== want || obs_q[0].nb !== 4'd3 || obs_q[0].last !== 1'b1) begin
            bad++; $display("FAIL short_vector got=%0d blocks first=%h want=1 block %h", obs_q.size(),
                (obs_q.size() > 0) ? obs_q[0].data : 64'h0, want);
        end
    endtask

    task automatic test_full_final();
        bq_t m;
        load_kn(rnd128(), rnd128(), 1'b0);
        m = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        run_msg(m, 0);
`ifdef ASCON_LOADER_PAD_EN
        total++;
        if (obs_q.size() != 2) begin
            bad++; $display("FAIL full_final_count got=%0d want=2", obs_q.size());
        end else if (obs_q[0].data !== 64'h0102030405060708 || obs_q[0].last !== 1'b0 ||
                     obs_q[1].data !== 64'h8000000000000000 || obs_q[1].nb !== 4'd0 || obs_q[1].last !== 1'b1) begin
            bad++; $display("FAIL full_final_pad got=%h/%b,%h/%0d/%b want=0102030405060708/0,8000000000000000/0/1",
                obs_q[0].data, obs_q[0].last, obs_q[1].data, obs_q[1].nb, obs_q[1].last);
        end
`else
        total++;
        if (obs_q.size() != 1 || obs_q[0].data !== 64'h0102030405060708 || obs_q[0].nb !== 4'd8 || obs_q[0].last !== 1'b1) begin
            bad++; $display("FAIL full_final got=%0d blocks want=1 block 0102030405060708/8/1", obs_q.size());
        end
`endif
    endtask

    task automatic test_stall();
        bq_t m;
        load_kn(rnd128(), rnd128(), 1'b0);
        m = {};
        for (int i = 0; i < 11; i++) m.push_back(8'($urandom()));
        run_msg(m, 10);
    endtask

    task automatic test_reset_mid();
        int err;
        bq_t m;
        load_kn(rnd128(), rnd128(), 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_byte = 8'($urandom()); in_valid = 1'b1; in_last = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++; if ({in_ready, kn_valid, blk_valid, blk_last} !== 4'b0000) begin bad++; $display("FAIL midrst_flags got=%b want=0000", {in_ready, kn_valid, blk_valid, blk_last}); end
        total++; if (key_out !== '0 || nonce_out !== '0) begin bad++; $display("FAIL midrst_kn got=%h/%h want=0", key_out, nonce_out); end
        total++; if (blk_out !== '0 || blk_bytes !== 4'd0) begin bad++; $display("FAIL midrst_blk got=%h/%0d want=0/0", blk_out, blk_bytes); end
        @(negedge clk);
        rst = 1'b0;
        err = 0;
        blk_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            in_byte = 8'($urandom()); in_valid = 1'($urandom_range(0, 1)); in_last = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (blk_valid !== 1'b0 || in_ready !== 1'b0) err++;
        end
        in_valid = 1'b0; in_last = 1'b0; blk_ready = 1'b0;
        total++; if (err != 0) begin bad++; $display("FAIL post_rst_quiet got=%0d active cycles want=0", err); end
        load_kn(rnd128(), rnd128(), 1'b0);
        m = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        run_msg(m, 0);
    endtask

    task automatic test_start_drop();
        bq_t m;
        logic [127:0] k2, n2;
        load_kn(rnd128(), rnd128(), 1'b0);
        for (int i = 0; i < 2; i++) begin
            in_byte = 8'($urandom()); in_valid = 1'b1; in_last = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        k2 = rnd128();
        n2 = rnd128();
        load_kn(k2, n2, 1'b1);
        m = '{8'h5A, 8'hA5};
        run_msg(m, 2);
    endtask

    task automatic test_random();
        bq_t m;
        int len;
        for (int t = 0; t < 8; t++) begin
            load_kn(rnd128(), rnd128(), 1'b0);
            len = $urandom_range(1, 20);
            m = {};
            for (int i = 0; i < len; i++) m.push_back(8'($urandom()));
            run_msg(m, $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_full_final();
        test_stall();
        test_reset_mid();
        test_start_drop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=completion");
        $fatal(1);
    end

endmodule
